// File: rtl/packet_assembler.sv
// Collects WORD_WIDTH-bit words into PACKET_WORDS-word packets behind a one-deep output slot.
// A partial packet can be flushed with padding after an idle timeout.
module packet_assembler #(
    parameter int WORD_WIDTH     = 8,
    parameter int PACKET_WORDS   = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter logic [WORD_WIDTH-1:0] PAD_WORD = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [WORD_WIDTH-1:0]                word,
    input  logic                                 write,
    input  logic                                 clear,
    input  logic                                 ready,
    output logic [PACKET_WORDS*WORD_WIDTH-1:0]   sys_packet,
    output logic                                 send,
    output logic [$clog2(PACKET_WORDS+1)-1:0]    length,
    output logic                                 overflow
);
    localparam int CW = $clog2(PACKET_WORDS+1);
    localparam int AW = $clog2(PACKET_WORDS);
    localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;
    localparam logic [0:0] S_FILL   = 1'b0;
    localparam logic [0:0] S_CLOSED = 1'b1;

    logic [PACKET_WORDS-1:0][WORD_WIDTH-1:0] fbuf;
    logic [CW-1:0] fill_count;
    logic [IW-1:0] idle_cnt;
    logic [0:0]    state;
    logic [AW-1:0] widx;
    logic          slot_free, transfer, idle_tick, timeout_fire;

    always_comb begin
        slot_free    = !send || ready;
        transfer     = (state == S_CLOSED) && slot_free;
        idle_tick    = (state == S_FILL) && (fill_count != '0) && !write;
        timeout_fire = (TIMEOUT_CYCLES > 0) && idle_tick &&
                       (idle_cnt == IW'(TIMEOUT_CYCLES-1));
        widx         = fill_count[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fbuf       <= '0;
            sys_packet <= '0;
            fill_count <= '0;
            idle_cnt   <= '0;
            length     <= '0;
            send       <= 1'b0;
            overflow   <= 1'b0;
            state      <= S_FILL;
        end else begin
            overflow <= 1'b0;
            if (clear) begin
                // Data registers keep stale contents; only the bookkeeping is dropped.
                fill_count <= '0;
                idle_cnt   <= '0;
                state      <= S_FILL;
                send       <= 1'b0;
            end else begin
                if (send && ready)
                    send <= 1'b0;
                if (transfer) begin
                    sys_packet <= fbuf;
                    length     <= fill_count;
                    send       <= 1'b1;
                    fill_count <= '0;
                    idle_cnt   <= '0;
                    state      <= S_FILL;
                end else if (timeout_fire) begin
                    for (int i = 0; i < PACKET_WORDS; i++)
                        if (CW'(i) >= fill_count)
                            fbuf[i] <= PAD_WORD;
                    idle_cnt <= '0;
                    state    <= S_CLOSED;
                end else if ((state == S_FILL) && write) begin
                    fbuf[widx] <= word;
                    fill_count <= fill_count + 1'b1;
                    idle_cnt   <= '0;
                    if (fill_count == CW'(PACKET_WORDS-1))
                        state <= S_CLOSED;
                end else if (idle_tick && (TIMEOUT_CYCLES > 0)) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                // Writes arriving while closed are lost, even on the transfer edge.
                if ((state == S_CLOSED) && write)
                    overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench: vector table on a default instance, plus hand sequences for the
// timeout-enabled and 12-bit/3-word instances.
module tb_packet_assembler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // default instance
    logic        rst_a, wr_a, clr_a, rdy_a;
    logic [7:0]  wd_a;
    logic [31:0] pkt_a;
    logic        send_a, ovf_a;
    logic [2:0]  len_a;
    packet_assembler dut_a (
        .clk(clk), .rst(rst_a), .word(wd_a), .write(wr_a), .clear(clr_a), .ready(rdy_a),
        .sys_packet(pkt_a), .send(send_a), .length(len_a), .overflow(ovf_a));

    // timeout instance
    logic        rst_t, wr_t, clr_t, rdy_t;
    logic [7:0]  wd_t;
    logic [31:0] pkt_t;
    logic        send_t, ovf_t;
    logic [2:0]  len_t;
    packet_assembler #(.TIMEOUT_CYCLES(3), .PAD_WORD(8'hEE)) dut_t (
        .clk(clk), .rst(rst_t), .word(wd_t), .write(wr_t), .clear(clr_t), .ready(rdy_t),
        .sys_packet(pkt_t), .send(send_t), .length(len_t), .overflow(ovf_t));

    // wide-word, short-packet instance
    logic        rst_w, wr_w, clr_w, rdy_w;
    logic [11:0] wd_w;
    logic [35:0] pkt_w;
    logic        send_w, ovf_w;
    logic [1:0]  len_w;
    packet_assembler #(.WORD_WIDTH(12), .PACKET_WORDS(3)) dut_w (
        .clk(clk), .rst(rst_w), .word(wd_w), .write(wr_w), .clear(clr_w), .ready(rdy_w),
        .sys_packet(pkt_w), .send(send_w), .length(len_w), .overflow(ovf_w));

    typedef struct {
        logic        rst, wr, clr, rdy;
        logic [7:0]  wd;
        logic        send;
        logic [31:0] pkt;
        logic [2:0]  len;
        logic        ovf;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic w, input logic [7:0] d, input logic c,
                     input logic rd, input logic s, input logic [31:0] p,
                     input logic [2:0] l, input logic o);
        vec_t x;
        x.rst = r; x.wr = w; x.wd = d; x.clr = c; x.rdy = rd;
        x.send = s; x.pkt = p; x.len = l; x.ovf = o;
        tv.push_back(x);
    endtask

    task automatic wait_send_t(output int n);
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (send_t) begin n = k; break; end
        end
    endtask

    initial begin
        int n;
        {rst_a, wr_a, clr_a, rdy_a, wd_a} = '0;
        {rst_t, wr_t, clr_t, wd_t} = '0; rdy_t = 1'b1;
        {rst_w, wr_w, clr_w, wd_w} = '0; rdy_w = 1'b1;

        // ready=1, four consecutive words, one-cycle send
        v(0,1,8'h11,0,1, 0,32'h0,0,0);
        v(0,1,8'h22,0,1, 0,32'h0,0,0);
        v(0,1,8'h33,0,1, 0,32'h0,0,0);
        v(0,1,8'h44,0,1, 0,32'h0,0,0);
        v(0,0,8'h00,0,1, 1,32'h44332211,4,0);
        v(0,0,8'h00,0,1, 0,32'h44332211,4,0);
        // ready=0: hold one packet, fill a second, drop a ninth word
        v(0,1,8'h01,0,0, 0,32'h44332211,4,0);
        v(0,1,8'h02,0,0, 0,32'h44332211,4,0);
        v(0,1,8'h03,0,0, 0,32'h44332211,4,0);
        v(0,1,8'h04,0,0, 0,32'h44332211,4,0);
        v(0,0,8'h00,0,0, 1,32'h04030201,4,0);
        v(0,1,8'h05,0,0, 1,32'h04030201,4,0);
        v(0,1,8'h06,0,0, 1,32'h04030201,4,0);
        v(0,1,8'h07,0,0, 1,32'h04030201,4,0);
        v(0,1,8'h08,0,0, 1,32'h04030201,4,0);
        v(0,1,8'h09,0,0, 1,32'h04030201,4,1);
        v(0,0,8'h00,0,1, 1,32'h08070605,4,0);
        v(0,0,8'h00,0,1, 0,32'h08070605,4,0);
        // clear with simultaneous write discards partial packet, no overflow
        v(0,1,8'hAA,0,1, 0,32'h08070605,4,0);
        v(0,1,8'hBB,0,1, 0,32'h08070605,4,0);
        v(0,1,8'hCC,1,1, 0,32'h08070605,4,0);
        v(0,1,8'h01,0,1, 0,32'h08070605,4,0);
        v(0,1,8'h02,0,1, 0,32'h08070605,4,0);
        v(0,1,8'h03,0,1, 0,32'h08070605,4,0);
        v(0,1,8'h04,0,1, 0,32'h08070605,4,0);
        v(0,0,8'h00,0,1, 1,32'h04030201,4,0);
        v(0,0,8'h00,0,1, 0,32'h04030201,4,0);
        // reset mid-packet with a pending send, then a fresh packet
        v(0,1,8'h11,0,0, 0,32'h04030201,4,0);
        v(0,1,8'h22,0,0, 0,32'h04030201,4,0);
        v(0,1,8'h33,0,0, 0,32'h04030201,4,0);
        v(0,1,8'h44,0,0, 0,32'h04030201,4,0);
        v(0,0,8'h00,0,0, 1,32'h44332211,4,0);
        v(0,1,8'h55,0,0, 1,32'h44332211,4,0);
        v(0,1,8'h66,0,0, 1,32'h44332211,4,0);
        v(0,1,8'h77,0,0, 1,32'h44332211,4,0);
        v(1,1,8'h88,1,1, 0,32'h0,0,0);
        v(0,1,8'h01,0,1, 0,32'h0,0,0);
        v(0,1,8'h02,0,1, 0,32'h0,0,0);
        v(0,1,8'h03,0,1, 0,32'h0,0,0);
        v(0,1,8'h04,0,1, 0,32'h0,0,0);
        v(0,0,8'h00,0,1, 1,32'h04030201,4,0);
        v(0,0,8'h00,0,1, 0,32'h04030201,4,0);
        // clear drops a held packet but keeps output data
        v(0,1,8'hA1,0,0, 0,32'h04030201,4,0);
        v(0,1,8'hA2,0,0, 0,32'h04030201,4,0);
        v(0,1,8'hA3,0,0, 0,32'h04030201,4,0);
        v(0,1,8'hA4,0,0, 0,32'h04030201,4,0);
        v(0,0,8'h00,0,0, 1,32'hA4A3A2A1,4,0);
        v(0,0,8'h00,1,0, 0,32'hA4A3A2A1,4,0);

        // reset all instances
        rst_a = 1'b1; rst_t = 1'b1; rst_w = 1'b1; wr_a = 1'b1; wd_a = 8'h5A;
        @(posedge clk); #1;
        chk("rst_send", {63'b0, send_a}, 64'd0);
        chk("rst_pkt",  {32'b0, pkt_a}, 64'd0);
        chk("rst_len",  {61'b0, len_a}, 64'd0);
        chk("rst_ovf",  {63'b0, ovf_a}, 64'd0);
        rst_a = 1'b0; rst_t = 1'b0; rst_w = 1'b0; wr_a = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            rst_a = tv[i].rst; wr_a = tv[i].wr; wd_a = tv[i].wd;
            clr_a = tv[i].clr; rdy_a = tv[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_send", i), {63'b0, send_a}, {63'b0, tv[i].send});
            chk($sformatf("v%0d_pkt", i),  {32'b0, pkt_a},  {32'b0, tv[i].pkt});
            chk($sformatf("v%0d_len", i),  {61'b0, len_a},  {61'b0, tv[i].len});
            chk($sformatf("v%0d_ovf", i),  {63'b0, ovf_a},  {63'b0, tv[i].ovf});
        end
        {rst_a, wr_a, clr_a} = '0;

        // timeout instance sat empty the whole time: must not have flushed
        chk("to_empty_nofire", {63'b0, send_t}, 64'd0);

        wr_t = 1'b1; wd_t = 8'hAA; @(posedge clk); #1;
        wd_t = 8'hBB; @(posedge clk); #1;
        wr_t = 1'b0;
        wait_send_t(n);
        chk("to_latency", 64'(n), 64'd4);
        chk("to_pkt", {32'b0, pkt_t}, 64'hEEEEBBAA);
        chk("to_len", {61'b0, len_t}, 64'd2);
        @(posedge clk); #1;
        chk("to_send_drop", {63'b0, send_t}, 64'd0);

        // write on the would-be timeout edge restarts the idle count
        wr_t = 1'b1; wd_t = 8'hCC; @(posedge clk); #1;
        wr_t = 1'b0; @(posedge clk); #1; @(posedge clk); #1;
        wr_t = 1'b1; wd_t = 8'hDD; @(posedge clk); #1;
        chk("to_cancel", {63'b0, send_t}, 64'd0);
        wr_t = 1'b0;
        wait_send_t(n);
        chk("to_cancel_latency", 64'(n), 64'd4);
        chk("to_cancel_pkt", {32'b0, pkt_t}, 64'hEEEEDDCC);
        chk("to_cancel_len", {61'b0, len_t}, 64'd2);

        // 12-bit words, 3-word packets
        wr_w = 1'b1; wd_w = 12'hABC; @(posedge clk); #1;
        wd_w = 12'h123; @(posedge clk); #1;
        wd_w = 12'hFFF; @(posedge clk); #1;
        chk("w_pre_send", {63'b0, send_w}, 64'd0);
        wr_w = 1'b0; @(posedge clk); #1;
        chk("w_send", {63'b0, send_w}, 64'd1);
        chk("w_pkt", {28'b0, pkt_w}, 64'hFFF123ABC);
        chk("w_len", {62'b0, len_w}, 64'd3);
        chk("w_ovf", {63'b0, ovf_w}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, bits per input word.
REQ-002 SHALL have parameter PACKET_WORDS, default 4, words per packet; legal range 2..256.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, idle cycles before a partial packet is flushed; 0 disables flushing.
REQ-004 SHALL have parameter PAD_WORD, default 0, WORD_WIDTH-bit fill value for unwritten words of a flushed packet.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port word  input  WORD_WIDTH  data word to append.
REQ-008 SHALL have port write  input  1  append word this cycle.
REQ-009 SHALL have port clear  input  1  discard all buffered data.
REQ-010 SHALL have port ready  input  1  downstream accepts sys_packet this cycle.
REQ-011 SHALL have port sys_packet  output  PACKET_WORDS*WORD_WIDTH  packet; word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-012 SHALL have port send  output  1  sys_packet/length valid.
REQ-013 SHALL have port length  output  $clog2(PACKET_WORDS+1)  count of real (non-pad) words in sys_packet.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse: a write was dropped.

Function
REQ-015 SHALL hold two registers: fill buffer (with fill_count) and output slot (with send flag); all outputs registered.
REQ-016 SHALL run a fill FSM with states FILL (accepting) and CLOSED (complete or flushed, awaiting output slot).
REQ-017 In FILL, write=1 SHALL store word at index fill_count and increment fill_count at that edge.
REQ-018 Acceptance of word PACKET_WORDS-1 SHALL move the FSM to CLOSED with length=PACKET_WORDS.
REQ-019 Handshake = send && ready; the output slot SHALL be free at an edge when send=0 or handshake=1.
REQ-020 In CLOSED with a free slot, SHALL transfer fill buffer to sys_packet/length, set send=1, set fill_count=0, return to FILL, all at that edge.
REQ-021 Packet latency: send SHALL assert one cycle after the edge accepting the last word if the slot is free at that next edge; held packets SHALL transfer on the first free-slot edge.
REQ-022 Handshake with no transfer at the same edge SHALL clear send; with a transfer, send SHALL stay 1 and sys_packet SHALL update to the new packet (back-to-back, no bubble).
REQ-023 sys_packet and length SHALL remain stable while send=1 and ready=0.
REQ-024 write=1 in CLOSED SHALL be dropped, including on the transfer edge, with overflow=1 for the following cycle.
REQ-025 When TIMEOUT_CYCLES>0, an idle counter SHALL increment each cycle in FILL with 0<fill_count and no write, and reset to 0 on any accepted write, transfer, or clear.
REQ-026 Idle counter reaching TIMEOUT_CYCLES SHALL set all words at index >= fill_count to PAD_WORD, set length=fill_count, enter CLOSED.
REQ-027 write=1 on the timeout edge SHALL be accepted and cancel the timeout.
REQ-028 Timeout SHALL never fire with fill_count=0; TIMEOUT_CYCLES=0 SHALL never flush.
REQ-029 clear=1 SHALL, at that edge, set fill_count=0, idle counter=0, FSM=FILL, send=0; write that cycle is ignored without overflow; data registers keep their values.
REQ-030 Priority SHALL be rst > clear > transfer/timeout > write.

Reset
REQ-031 rst=1 SHALL, at that edge, zero sys_packet, fill buffer, fill_count, idle counter, length, send, overflow and enter FILL, overriding all other inputs, including mid-packet.
REQ-032 First write SHALL be accepted on the first edge with rst=0.

Verification
REQ-033 Defaults, ready=1, write 0x11,0x22,0x33,0x44 consecutively -> send=1 next cycle for one cycle, sys_packet=0x44332211, length=4.
REQ-034 ready=0, write 8 words 0x01..0x08 then 0x09 -> sys_packet=0x04030201 held; 0x09 dropped with overflow pulse; ready=1 one cycle -> sys_packet=0x08070605, send stays 1.
REQ-035 TIMEOUT_CYCLES=3, PAD_WORD=0xEE, ready=1, write 0xAA,0xBB then idle -> send after 3 idle cycles, sys_packet=0xEEEEBBAA, length=2.
REQ-036 Write 2 words, clear=1 with write=1 same cycle, then 4 words 0x01..0x04 -> sys_packet=0x04030201, no overflow.
REQ-037 rst=1 after 3 words with send=1 pending -> next cycle send=0, sys_packet=0, length=0; 4 new words form a fresh packet.
REQ-038 WORD_WIDTH=12, PACKET_WORDS=3, write 0xABC,0x123,0xFFF -> sys_packet=0xFFF123ABC, length=3.
